// File: rtl/vedic_8b_rev_pkg.sv
// Shared widths for the reversible-logic Vedic multiplier.
package vedic_8b_rev_pkg;
  localparam int unsigned OP_W   = 8;
  localparam int unsigned PROD_W = 16;
  localparam int unsigned NIB_W  = 4;
endpackage

// File: rtl/vedic_4b_rev.sv
// Combinational 4x4 Vedic multiplier from four 2x2 blocks and reversible adders.

// 2x2 Vedic block: AND partial products summed with two Peres half adders.
module vedic_2b_rev (
  input  logic [1:0] a_i,
  input  logic [1:0] b_i,
  output logic [3:0] p_o
);
  logic cross_c;
  logic unused_p0;
  logic unused_p1;

  assign p_o[0] = a_i[0] & b_i[0];

  peres_gate u_cross (
    .a_i (a_i[1] & b_i[0]),
    .b_i (a_i[0] & b_i[1]),
    .c_i (1'b0),
    .p_o (unused_p0),
    .q_o (p_o[1]),
    .r_o (cross_c)
  );

  peres_gate u_high (
    .a_i (a_i[1] & b_i[1]),
    .b_i (cross_c),
    .c_i (1'b0),
    .p_o (unused_p1),
    .q_o (p_o[2]),
    .r_o (p_o[3])
  );
endmodule

module vedic_4b_rev
  import vedic_8b_rev_pkg::*;
(
  input  logic [NIB_W-1:0]   a_i,
  input  logic [NIB_W-1:0]   b_i,
  output logic [2*NIB_W-1:0] p_o
);
  logic [3:0] p_ll, p_hl, p_lh, p_hh;
  logic [3:0] cross_sum;
  logic       cross_cout;
  logic       unused_cout;

  vedic_2b_rev u_ll (.a_i(a_i[1:0]), .b_i(b_i[1:0]), .p_o(p_ll));
  vedic_2b_rev u_hl (.a_i(a_i[3:2]), .b_i(b_i[1:0]), .p_o(p_hl));
  vedic_2b_rev u_lh (.a_i(a_i[1:0]), .b_i(b_i[3:2]), .p_o(p_lh));
  vedic_2b_rev u_hh (.a_i(a_i[3:2]), .b_i(b_i[3:2]), .p_o(p_hh));

  // Crosswise term pHL + pLH, 5 bits including carry.
  rev_ripple_add #(.W(4)) u_cross (
    .a_i    (p_hl),
    .b_i    (p_lh),
    .sum_o  (cross_sum),
    .cout_o (cross_cout)
  );

  // pHH and pLL do not overlap, so they share one operand; the crosswise term is shifted by 2.
  rev_ripple_add #(.W(8)) u_final (
    .a_i    ({p_hh, p_ll}),
    .b_i    ({1'b0, cross_cout, cross_sum, 2'b00}),
    .sum_o  (p_o),
    .cout_o (unused_cout)
  );
endmodule

// File: rtl/vedic_8b_rev_cells.sv
// Reversible leaf cells and a ripple adder built from them.

// Peres gate: P=A, Q=A^B, R=(A&B)^C; with C=0 it is a half adder (Q=sum, R=carry).
module peres_gate (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic p_o,
  output logic q_o,
  output logic r_o
);
  assign p_o = a_i;
  assign q_o = a_i ^ b_i;
  assign r_o = (a_i & b_i) ^ c_i;
endmodule

// HNG gate: P=A, Q=B, R=A^B^C, S=((A^B)&C)^(A&B)^D; with D=0 it is a full adder.
module hng_gate (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  input  logic d_i,
  output logic p_o,
  output logic q_o,
  output logic r_o,
  output logic s_o
);
  assign p_o = a_i;
  assign q_o = b_i;
  assign r_o = a_i ^ b_i ^ c_i;
  assign s_o = ((a_i ^ b_i) & c_i) ^ (a_i & b_i) ^ d_i;
endmodule

// Ripple adder: Peres half adder on bit 0, HNG full adders above it.
module rev_ripple_add #(
  parameter int unsigned W = 4
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] sum_o,
  output logic         cout_o
);
  logic [W-1:0] carry;
  logic [W-1:0] unused_p;
  logic [W-1:0] unused_q;

  peres_gate u_ha (
    .a_i (a_i[0]),
    .b_i (b_i[0]),
    .c_i (1'b0),
    .p_o (unused_p[0]),
    .q_o (sum_o[0]),
    .r_o (carry[0])
  );
  assign unused_q[0] = 1'b0;

  for (genvar i = 1; i < int'(W); i++) begin : g_fa
    hng_gate u_fa (
      .a_i (a_i[i]),
      .b_i (b_i[i]),
      .c_i (carry[i-1]),
      .d_i (1'b0),
      .p_o (unused_p[i]),
      .q_o (unused_q[i]),
      .r_o (sum_o[i]),
      .s_o (carry[i])
    );
  end

  assign cout_o = carry[W-1];
endmodule

// File: rtl/vedic_8b_rev.sv
// Registered 8x8 unsigned Vedic multiplier using reversible-logic adders.
module vedic_8b_rev
  import vedic_8b_rev_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [OP_W-1:0]   a,
  input  logic [OP_W-1:0]   b,
  output logic [PROD_W-1:0] y
);
  logic [7:0]        p_ll, p_hl, p_lh, p_hh;
  logic [7:0]        cross_sum;
  logic              cross_cout;
  logic              unused_cout;
  logic [PROD_W-1:0] y_d;
  logic [PROD_W-1:0] y_q;

  vedic_4b_rev u_ll (.a_i(a[3:0]), .b_i(b[3:0]), .p_o(p_ll));
  vedic_4b_rev u_hl (.a_i(a[7:4]), .b_i(b[3:0]), .p_o(p_hl));
  vedic_4b_rev u_lh (.a_i(a[3:0]), .b_i(b[7:4]), .p_o(p_lh));
  vedic_4b_rev u_hh (.a_i(a[7:4]), .b_i(b[7:4]), .p_o(p_hh));

  // 8-bit crosswise adder, 9-bit result.
  rev_ripple_add #(.W(8)) u_cross (
    .a_i    (p_hl),
    .b_i    (p_lh),
    .sum_o  (cross_sum),
    .cout_o (cross_cout)
  );

  // Final 16-bit summation; the 16-bit result cannot carry out for 8x8 operands.
  rev_ripple_add #(.W(16)) u_final (
    .a_i    ({p_hh, p_ll}),
    .b_i    ({3'b000, cross_cout, cross_sum, 4'b0000}),
    .sum_o  (y_d),
    .cout_o (unused_cout)
  );

  // Output register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) y_q <= '0;
    else     y_q <= y_d;
  end

  assign y = y_q;
endmodule

// File: tb/tb_vedic_8b_rev.sv
// Scoreboard bench for vedic_8b_rev: stimulus pushes expectations, monitor compares.
module tb_vedic_8b_rev;
  typedef struct {
    logic [15:0] exp;
    string       name;
    logic [7:0]  ea;
    logic [7:0]  eb;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [7:0]  a;
  logic [7:0]  b;
  logic [15:0] y;

  exp_t sb[$];
  int   checks;
  int   errors;

  vedic_8b_rev dut (
    .clk (clk),
    .rst (rst),
    .a   (a),
    .b   (b),
    .y   (y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply operands at the falling edge and queue the value y must hold after the next rising edge.
  task automatic drive(input logic [7:0] ta, input logic [7:0] tb_v, input logic tr,
                       input logic [15:0] texp, input string tname);
    exp_t e;
    @(negedge clk);
    a   = ta;
    b   = tb_v;
    rst = tr;
    e.exp  = texp;
    e.name = tname;
    e.ea   = ta;
    e.eb   = tb_v;
    sb.push_back(e);
  endtask

  // Monitor: one expectation consumed per rising edge, sampled just after it.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if (y !== e.exp) begin
          errors++;
          $display("FAIL %s: a=%0d b=%0d y=%0d expected=%0d", e.name, e.ea, e.eb, y, e.exp);
        end
      end
    end
  end

  initial begin
    logic [7:0] ra, rb;
    checks = 0;
    errors = 0;
    rst = 1'b1;
    a   = 8'd0;
    b   = 8'd0;

    // Reset overrides full-scale operands and holds y at zero.
    for (int i = 0; i < 4; i++) drive(8'd255, 8'd255, 1'b1, 16'h0000, "reset");

    // Directed products, hand-computed.
    drive(8'd65,  8'd43,  1'b0, 16'h0AEB, "dir_65x43");
    drive(8'd23,  8'd47,  1'b0, 16'h0439, "dir_23x47");
    drive(8'd45,  8'd31,  1'b0, 16'h0573, "dir_45x31");
    drive(8'd0,   8'd173, 1'b0, 16'd0,    "bnd_0x173");
    drive(8'd1,   8'd200, 1'b0, 16'd200,  "bnd_1x200");
    drive(8'd255, 8'd255, 1'b0, 16'hFE01, "bnd_255x255");
    drive(8'd128, 8'd2,   1'b0, 16'h0100, "bnd_128x2");
    drive(8'd15,  8'd15,  1'b0, 16'd225,  "bnd_15x15");
    drive(8'd240, 8'd240, 1'b0, 16'hE100, "bnd_240x240");
    drive(8'd17,  8'd17,  1'b0, 16'd289,  "bnd_17x17");

    // Back-to-back random stream.
    for (int i = 0; i < 256; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      drive(ra, rb, 1'b0, 16'(ra) * 16'(rb), "stream");
    end

    // Mid-stream reset for one edge, then streaming resumes immediately.
    drive(8'd200, 8'd100, 1'b0, 16'd20000, "pre_rst");
    drive(8'd99,  8'd77,  1'b1, 16'd0,     "mid_rst");
    drive(8'd99,  8'd77,  1'b0, 16'd7623,  "post_rst");
    drive(8'd12,  8'd13,  1'b0, 16'd156,   "post_rst2");

    // Exhaustive sweep, one pair per cycle.
    for (int i = 0; i < 65536; i++) begin
      ra = 8'(i >> 8);
      rb = 8'(i);
      drive(ra, rb, 1'b0, 16'(ra) * 16'(rb), "exhaustive");
    end

    // Let the monitor drain the last expectation; anything left over is an error.
    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: pending=%0d expected=0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
